fir_coeff_loader: RTL and testbench

//  Upstream stage of the direct-form FIR filter. Accepts a stream of NUM_TAP signed coefficients over a

---
 rtl/fir_coeff_pkg.sv | 23 ++
 rtl/fir_load_watchdog.sv | 28 ++
 rtl/fir_coeff_loader.sv | 156 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient path: default geometry and load-sequencer state encoding.
package fir_coeff_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_NUM_TAP = 33;
    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned WD_W        = 8;

    // Encoding is shared with the filter controller, so values are pinned.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } load_state_e;

    // A set is in flight whenever the sequencer has left IDLE.
    function automatic logic is_busy(input load_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/fir_load_watchdog.sv
// Inter-beat idle counter; flags when the configured idle limit has been reached.
module fir_load_watchdog #(
    parameter int unsigned WD_W    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    logic [WD_W-1:0] cnt_q;

    assign expired_c = (cnt_q == WD_W'(TIMEOUT));

    // Clear has priority; counting stops at the terminal value so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expired_c) begin
            cnt_q <= cnt_q + WD_W'(1);
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Converts a valid/ready coefficient stream into coefficient-RAM writes for one complete set per load.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_TAP = DEF_NUM_TAP,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iLoadStart,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oCoeffiUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic ready_c;
    logic accept_c;
    logic last_beat_c;
    logic wd_clr;
    logic wd_inc;
    logic wd_expired_c;

    // Ready is a direct decode of state and tap count so a beat can be taken every cycle.
    assign ready_c     = (state_q == ST_LOAD) &&
                         ({1'b0, count_q} < (ADDR_W+1)'(NUM_TAP));
    assign accept_c    = iCoeffValid && ready_c;
    assign last_beat_c = (count_q == ADDR_W'(NUM_TAP - 1));

    fir_load_watchdog #(
        .WD_W    (WD_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (iClk_12M),
        .rst       (iRsn),
        .clr       (wd_clr),
        .inc       (wd_inc),
        .expired_c (wd_expired_c)
    );

    // Sequencer state register.
    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of the registered RAM port, flags and pulses.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        wd_clr  = 1'b1;
        wd_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (iLoadStart) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                wd_clr = accept_c;
                wd_inc = !accept_c;
                if (accept_c) begin
                    wr_n_d  = 1'b0;
                    addr_d  = count_q;
                    data_d  = iCoeffData;
                    count_d = count_q + ADDR_W'(1);
                    if (last_beat_c) begin
                        state_d = ST_DRAIN;
                    end
                end else if (wd_expired_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    count_d = '0;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                count_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        flag_d = is_busy(state_d);
        busy_d = is_busy(state_d);
    end

    // Tap counter, status flags and RAM write port registers.
    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign oCoeffReady       = ready_c;
    assign oCoeffiUpdateFlag = flag_q;
    assign oCsnRam           = wr_n_q;
    assign oWrnRam           = wr_n_q;
    assign oAddrRam          = addr_q;
    assign oWrDtRam          = data_q;
    assign oBusy             = busy_q;
    assign oDone             = done_q;
    assign oErr              = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised scoreboard bench for fir_coeff_loader against a load-sequence reference model.
module tb_fir_coeff_loader;

    localparam int NUM_TAP = 33;
    localparam int TIMEOUT = 255;
    localparam int BUDGET  = 2000;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_DRAIN = 3;

    logic        clk = 1'b0;
    logic        in_rsn = 1'b1;
    logic        in_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;

    logic        oCoeffReady;
    logic        oCoeffiUpdateFlag;
    logic        oCsnRam;
    logic        oWrnRam;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic        oBusy;
    logic        oDone;
    logic        oErr;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] mdl_ram [NUM_TAP];
    logic [15:0] dut_ram [NUM_TAP];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    // Reference model state: what the loader should be doing in the current cycle.
    int          m_phase = PH_IDLE;
    int          m_k = 0;
    int          m_wd = 0;
    int          m_addr = 0;
    logic [15:0] m_data = '0;
    logic        e_write = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;
    logic        e_busy = 1'b0;
    logic        e_ready = 1'b0;

    fir_coeff_loader dut (
        .iClk_12M          (clk),
        .iRsn              (in_rsn),
        .iLoadStart        (in_start),
        .iCoeffValid       (in_valid),
        .iCoeffData        (in_data),
        .oCoeffReady       (oCoeffReady),
        .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
        .oCsnRam           (oCsnRam),
        .oWrnRam           (oWrnRam),
        .oAddrRam          (oAddrRam),
        .oWrDtRam          (oWrDtRam),
        .oBusy             (oBusy),
        .oDone             (oDone),
        .oErr              (oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: advances on every edge from the bench's own inputs only.
    always @(posedge clk) begin
        bit acc;
        cyc++;
        acc = in_valid && (m_phase == PH_LOAD) && (m_k < NUM_TAP);
        e_write = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (in_rsn) begin
            m_phase = PH_IDLE;
            m_k     = 0;
            m_wd    = 0;
            m_addr  = 0;
            m_data  = '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (in_start) m_phase = PH_ARM;
                PH_ARM: begin
                    m_phase = PH_LOAD;
                    m_wd    = 0;
                end
                PH_LOAD: begin
                    if (acc) begin
                        exp_q.push_back('{m_k, in_data});
                        mdl_ram[m_k] = in_data;
                        m_addr  = m_k;
                        m_data  = in_data;
                        e_write = 1'b1;
                        m_k++;
                        m_wd = 0;
                        if (m_k == NUM_TAP) m_phase = PH_DRAIN;
                    end else if (m_wd == TIMEOUT) begin
                        m_phase = PH_IDLE;
                        e_err   = 1'b1;
                        m_k     = 0;
                    end else begin
                        m_wd++;
                    end
                end
                default: begin
                    m_phase = PH_IDLE;
                    e_done  = 1'b1;
                    m_k     = 0;
                end
            endcase
        end
        e_busy  = (m_phase != PH_IDLE);
        e_ready = (m_phase == PH_LOAD) && (m_k < NUM_TAP);
    end

    // Monitor: compares every cycle and pops the scoreboard on each RAM write.
    always @(negedge clk) begin
        wr_t w;
        check("ready", 32'(oCoeffReady), 32'(e_ready));
        check("busy", 32'(oBusy), 32'(e_busy));
        check("update_flag", 32'(oCoeffiUpdateFlag), 32'(e_busy));
        check("done", 32'(oDone), 32'(e_done));
        check("err", 32'(oErr), 32'(e_err));
        check("csn", 32'(oCsnRam), 32'(!e_write));
        check("wrn", 32'(oWrnRam), 32'(!e_write));
        if (oCsnRam === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write (cycle %0d)",
                         oAddrRam, oWrDtRam, cyc);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(oAddrRam), 32'(w.addr));
                check("wr_data", 32'(oWrDtRam), 32'(w.data));
            end
            if (int'(oAddrRam) < NUM_TAP) dut_ram[oAddrRam] = oWrDtRam;
        end else begin
            check("addr_hold", 32'(oAddrRam), 32'(m_addr));
            check("data_hold", 32'(oWrDtRam), 32'(m_data));
        end
        if (oDone === 1'b1) last_done_cyc = cyc;
    end

    // One load request: every_n>0 gives a fixed valid cadence, otherwise pct% random valid.
    task automatic run_load(input int every_n, input int pct, input bit pattern,
                            input int stall_at, input int rst_at, input bit restarts,
                            output int lat);
        int idx;
        int budget;
        int start_cyc;
        bit acc;
        idx = 0;
        budget = 0;
        lat = -1;
        last_done_cyc = -1;
        in_start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        in_start = 1'b0;
        while (idx < NUM_TAP && budget < BUDGET) begin
            if (stall_at >= 0 && idx > stall_at) in_valid = 1'b0;
            else if (every_n > 0) in_valid = (budget % every_n) == 0;
            else in_valid = ($urandom_range(99) < pct);
            in_data  = pattern ? 16'(idx * 3 - 50) : 16'($urandom);
            in_start = restarts && (idx == 5 || idx == 20);
            in_rsn   = (idx == rst_at);
            acc = in_valid && oCoeffReady && !in_rsn;
            @(posedge clk);
            #1;
            in_start = 1'b0;
            in_rsn   = 1'b0;
            if (acc) idx++;
            budget++;
            if (!oBusy) break;
        end
        in_valid = 1'b0;
        if (budget >= BUDGET) begin
            n_vec++;
            n_err++;
            $display("FAIL load_budget: got %0d beats expected %0d within %0d cycles", idx, NUM_TAP, BUDGET);
        end
        repeat (6) @(posedge clk);
        #1;
        // oDone is raised after one edge and consumed by the following one.
        if (last_done_cyc >= 0) lat = last_done_cyc + 1 - start_cyc;
    endtask

    initial begin
        int lat;
        for (int a = 0; a < NUM_TAP; a++) begin
            mdl_ram[a] = '0;
            dut_ram[a] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        in_rsn = 1'b0;

        // Idle: stray valid beats must not reach the RAM.
        repeat (12) begin
            in_valid = 1'($urandom_range(1));
            in_data  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // Full-rate load with the k*3-50 pattern; start-to-done must be the minimum.
        run_load(0, 100, 1'b1, -1, -1, 1'b0, lat);
        check("done_latency", 32'(lat), 32'(36));

        // Throttled: one beat every fourth cycle.
        run_load(4, 0, 1'b0, -1, -1, 1'b0, lat);
        check("throttled_done_seen", 32'(lat > 0), 32'(1));

        // Stall after beat 10 until the watchdog aborts, then a clean restart.
        run_load(0, 100, 1'b0, 10, -1, 1'b0, lat);
        check("stall_no_done", 32'(lat), 32'(-1));
        run_load(0, 70, 1'b0, -1, -1, 1'b0, lat);

        // Start requests while busy are ignored.
        run_load(0, 80, 1'b0, -1, -1, 1'b1, lat);
        check("restart_done_seen", 32'(lat > 0), 32'(1));

        // Random loads.
        repeat (3) run_load(0, 30 + int'($urandom_range(70)), 1'b0, -1, -1, 1'b1, lat);

        // Reset mid-load after 17 beats.
        run_load(0, 100, 1'b0, -1, 17, 1'b0, lat);
        check("reset_no_done", 32'(lat), 32'(-1));

        for (int a = 0; a < NUM_TAP; a++) begin
            check($sformatf("ram[%0d]", a), 32'(dut_ram[a]), 32'(mdl_ram[a]));
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
